ddr_port_arbiter: RTL

Four-client DDR command arbiter in the `ddr_clk` domain, between the frame write buffers, the line read buffers and the single DDR controller command/data port. It accepts one-cycle request pulses from two write clients (W0, W1) and two read clients (R0, R1) and latches them as pending. It grants pending requests in round-robin order, one burst at a time. It steers the handshake and data strobes of the controller port to the granted client only.

---
 rtl/ddr_port_arbiter_if.sv | 34 +++
 rtl/ddr_port_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter_if.sv
// ddr_port_arbiter_if
//   Command/data port between the arbiter and the single DDR controller.
//   master : arbiter side (drives command, write data; receives handshakes, read data)
//   slave  : controller side
//   ctrl_req/ctrl_wr/ctrl_addr/ctrl_len : command request, direction, address, length
//   ctrl_rdy/ctrl_done                  : command accepted, burst complete pulse
//   ctrl_wdata/ctrl_wdata_req           : write beat data and beat request
//   ctrl_rdata/ctrl_rdata_en            : read beat data and valid
interface ddr_port_arbiter_if #(
   parameter int ADDR_WIDTH = 27,
   parameter int LEN_WIDTH  = 16,
   parameter int DQ_WIDTH   = 32
);
   logic                    ctrl_req;
   logic                    ctrl_wr;
   logic [ADDR_WIDTH-1:0]   ctrl_addr;
   logic [LEN_WIDTH-1:0]    ctrl_len;
   logic                    ctrl_rdy;
   logic                    ctrl_done;
   logic [8*DQ_WIDTH-1:0]   ctrl_wdata;
   logic                    ctrl_wdata_req;
   logic [8*DQ_WIDTH-1:0]   ctrl_rdata;
   logic                    ctrl_rdata_en;

   modport master (
      output ctrl_req, ctrl_wr, ctrl_addr, ctrl_len, ctrl_wdata,
      input  ctrl_rdy, ctrl_done, ctrl_wdata_req, ctrl_rdata, ctrl_rdata_en
   );

   modport slave (
      input  ctrl_req, ctrl_wr, ctrl_addr, ctrl_len, ctrl_wdata,
      output ctrl_rdy, ctrl_done, ctrl_wdata_req, ctrl_rdata, ctrl_rdata_en
   );
endinterface

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter
//   Four-client round-robin arbiter (W0, W1, R0, R1) in front of one DDR
//   controller command/data port. Request pulses are latched as pending,
//   granted one burst at a time, and the controller strobes are steered to
//   the granted client only.
//   ddr_clk, ddr_rstn       : clock, asynchronous active-low reset
//   wN_req/addr/len         : write request pulse with start address and length
//   wN_rdy/done             : command accepted / burst complete for this writer
//   wN_wdata/wN_wdata_req   : writer data in / next-beat request out
//   rN_req/addr/len/rdy/done: same for readers
//   rN_rdata/rN_rdata_en    : broadcast read data / per-reader beat valid
//   ctrl                    : controller port (master side)
//   req_ovf                 : sticky dropped-request flags {r1,r0,w1,w0}
module ddr_port_arbiter #(
   parameter int ADDR_WIDTH = 27,
   parameter int LEN_WIDTH  = 16,
   parameter int DQ_WIDTH   = 32
) (
   input  logic                  ddr_clk,
   input  logic                  ddr_rstn,
   input  logic                  w0_req,
   input  logic [ADDR_WIDTH-1:0] w0_addr,
   input  logic [LEN_WIDTH-1:0]  w0_len,
   output logic                  w0_rdy,
   output logic                  w0_done,
   input  logic [8*DQ_WIDTH-1:0] w0_wdata,
   output logic                  w0_wdata_req,
   input  logic                  w1_req,
   input  logic [ADDR_WIDTH-1:0] w1_addr,
   input  logic [LEN_WIDTH-1:0]  w1_len,
   output logic                  w1_rdy,
   output logic                  w1_done,
   input  logic [8*DQ_WIDTH-1:0] w1_wdata,
   output logic                  w1_wdata_req,
   input  logic                  r0_req,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   input  logic [LEN_WIDTH-1:0]  r0_len,
   output logic                  r0_rdy,
   output logic                  r0_done,
   output logic [8*DQ_WIDTH-1:0] r0_rdata,
   output logic                  r0_rdata_en,
   input  logic                  r1_req,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   input  logic [LEN_WIDTH-1:0]  r1_len,
   output logic                  r1_rdy,
   output logic                  r1_done,
   output logic [8*DQ_WIDTH-1:0] r1_rdata,
   output logic                  r1_rdata_en,
   ddr_port_arbiter_if.master    ctrl,
   output logic [3:0]            req_ovf
);

   typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;

   state_t                state, state_nxt;
   logic [3:0]            req_v;
   logic [ADDR_WIDTH-1:0] req_addr [4];
   logic [LEN_WIDTH-1:0]  req_len  [4];
   logic [3:0]            pending;
   logic [ADDR_WIDTH-1:0] pend_addr [4];
   logic [LEN_WIDTH-1:0]  pend_len  [4];
   logic [1:0]            rr_ptr, grant, pick;
   logic                  pick_v, take;
   logic [3:0]            consume, gnt_oh;

   // Client index order: 0=W0, 1=W1, 2=R0, 3=R1
   always_comb begin
      req_v       = {r1_req, r0_req, w1_req, w0_req};
      req_addr[0] = w0_addr;
      req_addr[1] = w1_addr;
      req_addr[2] = r0_addr;
      req_addr[3] = r1_addr;
      req_len[0]  = w0_len;
      req_len[1]  = w1_len;
      req_len[2]  = r0_len;
      req_len[3]  = r1_len;
   end

   // First pending client at or after rr_ptr, searching cyclically
   always_comb begin
      logic [1:0] idx;
      idx    = '0;
      pick   = rr_ptr;
      pick_v = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         idx = rr_ptr + 2'(i);
         if (!pick_v && pending[idx]) begin
            pick   = idx;
            pick_v = 1'b1;
         end
      end
   end

   assign take    = (state == IDLE) && pick_v;
   assign consume = take ? (4'b0001 << pick) : '0;

   // A pulse landing on the cycle its latch is granted refills the latch
   // instead of counting as an overflow.
   always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) begin
         pending <= '0;
         req_ovf <= '0;
         for (int unsigned n = 0; n < 4; n++) begin
            pend_addr[n] <= '0;
            pend_len[n]  <= '0;
         end
      end else begin
         for (int unsigned n = 0; n < 4; n++) begin
            if (req_v[n]) begin
               if (!pending[n] || consume[n]) begin
                  pending[n]   <= 1'b1;
                  pend_addr[n] <= req_addr[n];
                  pend_len[n]  <= req_len[n];
               end else begin
                  req_ovf[n] <= 1'b1;
               end
            end else if (consume[n]) begin
               pending[n] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) begin
         grant          <= '0;
         rr_ptr         <= '0;
         ctrl.ctrl_wr   <= 1'b0;
         ctrl.ctrl_addr <= '0;
         ctrl.ctrl_len  <= '0;
      end else if (take) begin
         grant          <= pick;
         rr_ptr         <= pick + 2'd1;
         ctrl.ctrl_wr   <= ~pick[1];
         ctrl.ctrl_addr <= pend_addr[pick];
         ctrl.ctrl_len  <= pend_len[pick];
      end
   end

   // State register
   always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
      if (!ddr_rstn) state <= IDLE;
      else           state <= state_nxt;
   end

   // Next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_v)         state_nxt = ISSUE;
         ISSUE:   if (ctrl.ctrl_rdy)  state_nxt = XFER;
         XFER:    if (ctrl.ctrl_done) state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Outputs: strobes steered to the granted client, all zero in IDLE
   always_comb begin
      gnt_oh          = 4'b0001 << grant;
      ctrl.ctrl_req   = (state == ISSUE);
      ctrl.ctrl_wdata = '0;
      {r1_rdy, r0_rdy, w1_rdy, w0_rdy}     = '0;
      {r1_done, r0_done, w1_done, w0_done} = '0;
      {w1_wdata_req, w0_wdata_req}         = '0;
      {r1_rdata_en, r0_rdata_en}           = '0;
      r0_rdata = ctrl.ctrl_rdata;
      r1_rdata = ctrl.ctrl_rdata;
      if (state == ISSUE && ctrl.ctrl_rdy)
         {r1_rdy, r0_rdy, w1_rdy, w0_rdy} = gnt_oh;
      if (state == XFER && ctrl.ctrl_done)
         {r1_done, r0_done, w1_done, w0_done} = gnt_oh;
      if (state != IDLE) begin
         if (!grant[1]) begin
            ctrl.ctrl_wdata = grant[0] ? w1_wdata : w0_wdata;
            if (ctrl.ctrl_wdata_req) {w1_wdata_req, w0_wdata_req} = gnt_oh[1:0];
         end else if (ctrl.ctrl_rdata_en) begin
            {r1_rdata_en, r0_rdata_en} = gnt_oh[3:2];
         end
      end
   end

endmodule
